// File: rtl/alu_result_stage.sv
// ALU result consumer: 2-entry skid buffer toward memory, branch resolution,
// EPC and SIIC/RTI trap sequencing. Define OFL_TRAP_EN to trap on ADD/SUB overflow.
module alu_result_stage #(
  parameter logic [15:0] TRAP_VEC = 16'h0002,
  parameter int          DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [DW-1:0] in_result,
  input  logic          in_ofl,
  input  logic          in_zero,
  input  logic [DW-1:0] in_pc,
  input  logic [DW-1:0] in_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_op,
  output logic [DW-1:0] out_result,
  output logic [DW-1:0] out_pc,
  output logic          redirect_valid,
  output logic [DW-1:0] redirect_pc,
  output logic [DW-1:0] epc,
  output logic          halted
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_BEQZ = 5'd16;
  localparam logic [4:0] OP_BNEZ = 5'd17;
  localparam logic [4:0] OP_BLTZ = 5'd18;
  localparam logic [4:0] OP_SIIC = 5'd26;
  localparam logic [4:0] OP_RTI  = 5'd27;
  localparam logic [4:0] OP_NOP  = 5'd28;
  localparam logic [4:0] OP_HALT = 5'd29;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALTED} state_t;

  typedef struct packed {
    logic [4:0]    op;
    logic [DW-1:0] result;
    logic [DW-1:0] pc;
  } entry_t;

  state_t        state_q, state_d;
  entry_t        head_q, head_d, skid_q, skid_d, enq;
  logic [1:0]    count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          redir_q, redir_d;
  logic          halted_q, halted_d;
  logic [DW-1:0] redir_pc_q, redir_pc_d;
  logic [DW-1:0] epc_q, epc_d;
  logic          accept, emit, take, ofl_trap;
  logic [DW-1:0] take_pc;

  assign accept = in_valid & in_ready_q;
  assign emit   = (count_q != 2'd0) & out_ready;

`ifndef OFL_TRAP_EN
  logic unused_ofl;
  assign unused_ofl = in_ofl;
`endif

  // Decode of the op presented this cycle: redirect decision and enqueued entry
  always_comb begin
    take     = 1'b0;
    take_pc  = in_target;
    ofl_trap = 1'b0;
`ifdef OFL_TRAP_EN
    ofl_trap = ((in_op == OP_ADD) || (in_op == OP_SUB)) && in_ofl;
`endif
    case (in_op)
      OP_BEQZ: take = in_zero;
      OP_BNEZ: take = ~in_zero;
      OP_BLTZ: take = in_result[DW-1];
      OP_SIIC: begin take = 1'b1; take_pc = TRAP_VEC; end
      OP_RTI:  begin take = 1'b1; take_pc = epc_q;    end
      default: ;
    endcase
    if (ofl_trap) begin
      take    = 1'b1;
      take_pc = TRAP_VEC;
    end
    enq.op     = ofl_trap ? OP_NOP : in_op;
    enq.result = in_result;
    enq.pc     = in_pc;
  end

  always_comb begin
    state_d    = state_q;
    redir_d    = 1'b0;
    redir_pc_d = redir_pc_q;
    epc_d      = epc_q;
    halted_d   = halted_q;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          if (take) begin
            state_d    = S_FLUSH;
            redir_d    = 1'b1;
            redir_pc_d = take_pc;
          end else if (in_op == OP_HALT) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end
          if (in_op == OP_SIIC) epc_d = in_pc + DW'(2);
          if (ofl_trap)         epc_d = in_pc;
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_HALTED;
    endcase

    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    case ({accept, emit})
      2'b10: begin
        if (count_q == 2'd0) head_d = enq;
        else                 skid_d = enq;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // A lone head is left in place so out_* hold their value once empty
        if (count_q == 2'd2) head_d = skid_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) head_d = enq;
        else begin
          head_d = skid_q;
          skid_d = enq;
        end
      end
      default: ;
    endcase

    in_ready_d = (state_d == S_RUN) && (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      head_q     <= '0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      epc_q      <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      epc_q      <= epc_d;
      halted_q   <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = (count_q != 2'd0);
  assign out_op         = head_q.op;
  assign out_result     = head_q.result;
  assign out_pc         = head_q.pc;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
  assign epc            = epc_q;
  assign halted         = halted_q;

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-side consumer of the ALU result interface: Out/OFL/Zero plus the 5-bit op that produced them.
- Buffers ALU results into the memory stage through a 2-entry skid buffer with valid/ready handshakes.
- Resolves conditional branches from Zero and Out[15].
- Owns the EPC register and the SIIC/RTI/overflow trap sequencing, which the ALU leaves undefined.

Parameters:
- TRAP_VEC, 16'h0002, redirect target for SIIC and overflow traps.
- DW, 16, datapath width; the datapath is fixed at 16, and the parameter exists only for readability.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept this cycle
- in_op  in  5  op code: ADD=0 SUB=1 BEQZ=16 BNEZ=17 BLTZ=18 SIIC=26 RTI=27 HALT=29; others pass-through
- in_result  in  16  ALU Out
- in_ofl  in  1  ALU OFL, already sign-selected
- in_zero  in  1  ALU Zero (Rs==0)
- in_pc  in  16  PC of the instruction
- in_target  in  16  branch target, PC+2+imm
- out_valid  out  1  entry available to memory stage
- out_ready  in  1  memory stage accepts
- out_op  out  5  op of head entry
- out_result  out  16  result of head entry
- out_pc  out  16  PC of head entry
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  16  redirect target
- epc  out  16  exception PC register
- halted  out  1  HALT accepted

Behaviour:
- Reset: all outputs 0; buffer empty; FSM=RUN; epc=0. Reset mid-transfer discards all entries and any pending redirect.
- Handshake:
  - Accept occurs when in_valid & in_ready.
  - Emit occurs when out_valid & out_ready.
  - in_ready = (state==RUN) & !skid_full, and is registered.
  - Entries leave in order. Zero-bubble: an accept into an empty buffer appears on out_valid the next cycle.
- Buffer boundaries:
  - Buffer has 2 entries.
  - Full with simultaneous accept+emit: count holds. This cannot occur when in_ready=0.
  - Empty: out_valid=0 and out_* hold their last values.
- Every accepted op enqueues, including branches, SIIC, RTI and HALT.
- Branch resolution at accept:
  - BEQZ is taken when in_zero=1.
  - BNEZ is taken when in_zero=0.
  - BLTZ is taken when in_result[15]=1.
- Taken branch:
  - Next cycle, redirect_valid=1 and redirect_pc=in_target, for exactly 1 cycle.
  - FSM goes RUN->FLUSH for that cycle; in_ready=0, so no wrong-path accept; then FLUSH->RUN.
- SIIC:
  - epc <= in_pc+2 (mod 2^16, 16'hFFFE+2=0).
  - Redirect to TRAP_VEC via FLUSH.
  - A nested SIIC overwrites epc.
- RTI: redirect to current epc via FLUSH. epc is unchanged.
- HALT: FSM -> HALTED; in_ready=0 until rst; halted=1 from the next cycle. Buffered entries, including HALT, still drain.
- Not-taken branch and all other ops: no redirect.
- Redirect priority: at most one redirect source per accept; accepts are blocked during FLUSH, so sources never collide.

Optional Feature:
- OFL_TRAP_EN defined:
  - ADD or SUB accepted with in_ofl=1 is an overflow trap.
  - epc <= in_pc; redirect to TRAP_VEC via FLUSH.
  - The entry is enqueued with out_op forced to NOP (28), which suppresses writeback.
- OFL_TRAP_EN undefined: in_ofl is ignored; ADD/SUB pass through unchanged.

Test Plan:
- Stream: 5 ADD results (1..5) with out_ready=1 -> out_result 1..5 in order, 1-cycle latency, no redirect.
- Backpressure: out_ready=0, offer 3 entries -> 2 accepted, in_ready=0; raise out_ready -> both emitted in order, the third then accepted.
- BEQZ in_zero=1, in_target=16'h0040 -> next cycle redirect_valid=1, redirect_pc=16'h0040 for 1 cycle, in_ready=0 that cycle. BNEZ with in_zero=1 -> no redirect.
- SIIC at in_pc=16'h0100, then RTI -> first redirect to 16'h0002 with epc=16'h0102; RTI redirects to 16'h0102.
- With OFL_TRAP_EN: ADD in_ofl=1 at in_pc=16'h0200 -> epc=16'h0200, redirect 16'h0002, out_op=28. Without the macro -> out_op=0, no redirect.
- HALT with 1 entry queued, then rst asserted mid-stream -> halted=1 and in_ready=0 after HALT; rst clears buffer, halted and epc asynchronously.
